mdc_r2_butterfly: RTL
=====================

Name: mdc_r2_butterfly

Overview:
- Radix-2 DIF butterfly stage of the multipath-delay-commutator FFT pipeline.
- Sits directly upstream of delay_commutator and drives its x0/x1 inputs.
- Each valid cycle takes one complex sample pair and computes y0 = (x0+x1) and y1 = (x0-x1)·W^k. The twiddle W^k comes from an external registered twiddle ROM; this block generates the ROM address.
- Fully pipelined; accepts one pair per clock with arbitrary in_valid gaps.

Parameters:
- FFT_N, 8, FFT length; power of two, ≥4.
- STAGE, 0, stage index, 0..log2(FFT_N)-1.
- DATA_WIDTH, 16, bits per real/imag component; two's complement.
- TW_WIDTH, 16, twiddle component width; Q1.(TW_WIDTH-1).
- SCALE, 1, 1 = divide butterfly sum/diff by 2 (arithmetic shift right, truncate); 0 = no scaling, wrap-free saturation to DATA_WIDTH.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high.
- in_valid, input, 1, x0/x1 hold a valid pair this cycle.
- x0_re, x0_im, input, DATA_WIDTH each, upper-path sample.
- x1_re, x1_im, input, DATA_WIDTH each, lower-path sample.
- tw_addr, output, log2(FFT_N/2), twiddle ROM address; combinational from pair counter.
- tw_re, tw_im, input, TW_WIDTH each, ROM data; registered ROM, valid one cycle after tw_addr.
- y0_re, y0_im, output, DATA_WIDTH each, sum path.
- y1_re, y1_im, output, DATA_WIDTH each, twiddled difference path.
- out_valid, output, 1, y0/y1 valid.

Behaviour:
- Reset: synchronous, active-high. Pair counter = 0; valid pipe cleared; y0/y1 = 0; out_valid = 0. A reset mid-frame discards all in-flight pairs; the next valid pair after reset uses counter 0.
- Pair counter cnt: width log2(FFT_N/2). Increments only on cycles where in_valid=1 and reset=0. Wraps from FFT_N/2-1 to 0.
- Twiddle index: k = (cnt mod (FFT_N>>(STAGE+1))) << STAGE.
  - tw_addr = k, driven every cycle regardless of in_valid.
  - For FFT_N=8: STAGE0 gives k=0,1,2,3; STAGE1 gives 0,2,0,2; STAGE2 gives 0 always.
- ROM contract: tw = round(cos(2πk/N)·2^(TW_WIDTH-1)) and -round(sin(2πk/N)·2^(TW_WIDTH-1)). Entries at k=0 are don't-care.
- Pipeline, with a pair accepted at edge t:
  - Edge t: register s = x0+x1 and d = x0-x1 per component, at DATA_WIDTH+1 bits. If SCALE=1, apply >>>1 (result fits DATA_WIDTH); else saturate to DATA_WIDTH. Also register a bypass flag = (k==0). The ROM latches tw_addr on the same edge.
  - Edge t+1: register the four products d_re·tw_re, d_im·tw_im, d_re·tw_im, d_im·tw_re at full width. Delay s and the bypass flag alongside.
  - Edge t+2: form re = p_rr − p_ii and im = p_ri + p_ir. Round by adding 2^(TW_WIDTH-2), then arithmetic shift right by TW_WIDTH-1. Saturate to [−2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)−1]. If bypass, y1 = d exactly. y0 = s.
  - out_valid is high in the cycle after edge t+2, so latency is 3 clocks. Throughput is 1 pair per clock.
- Idle cycles: when out_valid=0, y0/y1 hold their last registered value. No pipeline bubble is created internally.
- Back-to-back frames: the counter wrap carries straight into the next frame with no dead cycle.
- No backpressure: the downstream stage always accepts.

Test Plan:
- Reset/idle: hold reset 2 cycles, then in_valid=0 for 5 cycles → out_valid=0, y*=0, tw_addr=0 throughout.
- STAGE=0, SCALE=1, x0=(100,0), x1=(20,0), k=0 → 3 clocks later y0=(60,0), y1=(40,0), out_valid=1 for exactly 1 cycle.
- Same inputs on the second pair (k=1), ROM returns (23170,−23170) → y1=(28,−28), y0=(60,0).
- Address sequence: stream 12 consecutive pairs at STAGE=0, then STAGE=1, FFT_N=8 → tw_addr is 0,1,2,3 repeated for STAGE=0 and 0,2,0,2… for STAGE=1. out_valid stays high continuously, delayed 3 cycles from in_valid.
- Gaps and reset mid-frame: valid, idle, valid, then reset asserted with 2 pairs in flight → in-flight outputs never appear. The first pair after reset gets tw_addr=0. The gapped pairs get consecutive k values.
- Saturation, SCALE=0: x0=(32767,−32768), x1=(32767,32767), k=0 → y0=(32767,−1), y1=(0,−32768).

Source files
------------

// File: rtl/mdc_r2_butterfly.sv
// Radix-2 DIF butterfly for the MDC FFT pipeline: y0 = x0+x1, y1 = (x0-x1)*W^k.
// Three-cycle latency, one pair per clock, twiddle address generated for an external registered ROM.
module mdc_r2_butterfly #(
  parameter int FFT_N      = 8,
  parameter int STAGE      = 0,
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH   = 16,
  parameter int SCALE      = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic signed [DATA_WIDTH-1:0]      x0_re,
  input  logic signed [DATA_WIDTH-1:0]      x0_im,
  input  logic signed [DATA_WIDTH-1:0]      x1_re,
  input  logic signed [DATA_WIDTH-1:0]      x1_im,
  output logic        [$clog2(FFT_N/2)-1:0] tw_addr,
  input  logic signed [TW_WIDTH-1:0]        tw_re,
  input  logic signed [TW_WIDTH-1:0]        tw_im,
  output logic signed [DATA_WIDTH-1:0]      y0_re,
  output logic signed [DATA_WIDTH-1:0]      y0_im,
  output logic signed [DATA_WIDTH-1:0]      y1_re,
  output logic signed [DATA_WIDTH-1:0]      y1_im,
  output logic                              out_valid
);

  localparam int CW = $clog2(FFT_N / 2);
  localparam int DW = DATA_WIDTH;
  localparam int TW = TW_WIDTH;
  localparam int PW = DW + TW;
  localparam logic [CW-1:0]     K_MASK = CW'((FFT_N >> (STAGE + 1)) - 1);
  localparam logic signed [PW:0] RND   = {{(PW - TW + 2){1'b0}}, 1'b1, {(TW - 2){1'b0}}};

  function automatic logic signed [DW-1:0] sat_narrow(input logic signed [DW:0] v);
    logic signed [DW-1:0] r;
    if (v[DW] == v[DW-1]) begin
      r = v[DW-1:0];
    end else if (v[DW]) begin
      r = {1'b1, {(DW - 1){1'b0}}};
    end else begin
      r = {1'b0, {(DW - 1){1'b1}}};
    end
    return r;
  endfunction

  function automatic logic signed [DW-1:0] sat_wide(input logic signed [PW:0] v);
    logic [PW-DW+1:0]     hi;
    logic signed [DW-1:0] r;
    hi = v[PW:DW-1];
    if ((&hi) || !(|hi)) begin
      r = v[DW-1:0];
    end else if (v[PW]) begin
      r = {1'b1, {(DW - 1){1'b0}}};
    end else begin
      r = {1'b0, {(DW - 1){1'b1}}};
    end
    return r;
  endfunction

  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_k;
  logic signed [DW:0]   w_s_re, w_s_im, w_d_re, w_d_im;
  logic signed [DW-1:0] w_s_re_n, w_s_im_n, w_d_re_n, w_d_im_n;

  logic                 r_v1, r_byp1;
  logic signed [DW-1:0] r_s1_re, r_s1_im, r_d1_re, r_d1_im;
  logic                 r_v2, r_byp2;
  logic signed [DW-1:0] r_s2_re, r_s2_im, r_d2_re, r_d2_im;
  logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic signed [PW:0]   w_re_sum, w_im_sum, w_re_rnd, w_im_rnd, w_re_sh, w_im_sh;

  logic                 r_v3;
  logic signed [DW-1:0] r_y0_re, r_y0_im, r_y1_re, r_y1_im;

  // Stride-folded twiddle index; fewer distinct twiddles each later stage.
  always_comb begin
    w_k = (r_cnt & K_MASK) << STAGE;
  end

  assign tw_addr = w_k;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= {CW{1'b0}};
    end else if (in_valid) begin
      r_cnt <= r_cnt + {{(CW - 1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  always_comb begin
    w_s_re = {x0_re[DW-1], x0_re} + {x1_re[DW-1], x1_re};
    w_s_im = {x0_im[DW-1], x0_im} + {x1_im[DW-1], x1_im};
    w_d_re = {x0_re[DW-1], x0_re} - {x1_re[DW-1], x1_re};
    w_d_im = {x0_im[DW-1], x0_im} - {x1_im[DW-1], x1_im};
    // Dropping the LSB of the DW+1 result is the truncating >>>1.
    w_s_re_n = (SCALE != 0) ? w_s_re[DW:1] : sat_narrow(w_s_re);
    w_s_im_n = (SCALE != 0) ? w_s_im[DW:1] : sat_narrow(w_s_im);
    w_d_re_n = (SCALE != 0) ? w_d_re[DW:1] : sat_narrow(w_d_re);
    w_d_im_n = (SCALE != 0) ? w_d_im[DW:1] : sat_narrow(w_d_im);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_byp1  <= 1'b0;
      r_s1_re <= {DW{1'b0}};
      r_s1_im <= {DW{1'b0}};
      r_d1_re <= {DW{1'b0}};
      r_d1_im <= {DW{1'b0}};
    end else begin
      r_v1    <= in_valid;
      r_byp1  <= (w_k == {CW{1'b0}});
      r_s1_re <= w_s_re_n;
      r_s1_im <= w_s_im_n;
      r_d1_re <= w_d_re_n;
      r_d1_im <= w_d_im_n;
    end
  end

  // ROM data for the pair in stage 1 arrives this cycle, aligned with r_d1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v2    <= 1'b0;
      r_byp2  <= 1'b0;
      r_s2_re <= {DW{1'b0}};
      r_s2_im <= {DW{1'b0}};
      r_d2_re <= {DW{1'b0}};
      r_d2_im <= {DW{1'b0}};
      r_p_rr  <= {PW{1'b0}};
      r_p_ii  <= {PW{1'b0}};
      r_p_ri  <= {PW{1'b0}};
      r_p_ir  <= {PW{1'b0}};
    end else begin
      r_v2    <= r_v1;
      r_byp2  <= r_byp1;
      r_s2_re <= r_s1_re;
      r_s2_im <= r_s1_im;
      r_d2_re <= r_d1_re;
      r_d2_im <= r_d1_im;
      r_p_rr  <= PW'(r_d1_re) * PW'(tw_re);
      r_p_ii  <= PW'(r_d1_im) * PW'(tw_im);
      r_p_ri  <= PW'(r_d1_re) * PW'(tw_im);
      r_p_ir  <= PW'(r_d1_im) * PW'(tw_re);
    end
  end

  always_comb begin
    w_re_sum = {r_p_rr[PW-1], r_p_rr} - {r_p_ii[PW-1], r_p_ii};
    w_im_sum = {r_p_ri[PW-1], r_p_ri} + {r_p_ir[PW-1], r_p_ir};
    w_re_rnd = w_re_sum + RND;
    w_im_rnd = w_im_sum + RND;
    w_re_sh  = w_re_rnd >>> (TW - 1);
    w_im_sh  = w_im_rnd >>> (TW - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v3    <= 1'b0;
      r_y0_re <= {DW{1'b0}};
      r_y0_im <= {DW{1'b0}};
      r_y1_re <= {DW{1'b0}};
      r_y1_im <= {DW{1'b0}};
    end else if (r_v2) begin
      r_v3    <= 1'b1;
      r_y0_re <= r_s2_re;
      r_y0_im <= r_s2_im;
      r_y1_re <= r_byp2 ? r_d2_re : sat_wide(w_re_sh);
      r_y1_im <= r_byp2 ? r_d2_im : sat_wide(w_im_sh);
    end else begin
      r_v3    <= 1'b0;
      r_y0_re <= r_y0_re;
      r_y0_im <= r_y0_im;
      r_y1_re <= r_y1_re;
      r_y1_im <= r_y1_im;
    end
  end

  assign out_valid = r_v3;
  assign y0_re     = r_y0_re;
  assign y0_im     = r_y0_im;
  assign y1_re     = r_y1_re;
  assign y1_im     = r_y1_im;

endmodule
